led_indicator_arbiter: RTL and testbench
========================================

Name: led_indicator_arbiter

Overview:
- Shares the 4 front-panel LEDs between several status sources: tap tempo, clip detect, preset change, bypass and similar.
- Each source posts a one-shot display request carrying a 4-bit pattern and a blink flag.
- The arbiter grants the LEDs by fixed priority for a timed hold window measured in audio sample ticks, then returns to the default (bypass/status) LEDs.
- Sits between the effect modules and the LED output stage of the power-up LED controller.

Parameters:
NUM_REQ, 4, number of requesters; index 0 is highest priority.
HOLD_W, 16, width of the hold and blink counters.
HOLD_TICKS, 24000, hold window in sample ticks (0.5 s at 48 kHz); legal range 1..2^HOLD_W-1.
BLINK_DIV, 6000, sample ticks per blink half-period; legal range 1..2^HOLD_W-1.

Ports:
clk_i  in  1  system clock
srst_i  in  1  reset
sample_tick_i  in  1  one-clk pulse per audio sample
default_leds_i  in  4  LED value shown when no request owns the display
req_i  in  NUM_REQ  one-clk request pulses
pattern_i  in  4*NUM_REQ  pattern of requester i in bits [4i+3:4i]; sampled with req_i[i]
blink_i  in  NUM_REQ  blink flag of requester i; sampled with req_i[i]
leds_o  out  4  registered LED drive
owner_o  out  $clog2(NUM_REQ)  index of the current owner; 0 when idle
busy_o  out  1  high while in SHOW_S
grant_o  out  NUM_REQ  one-clk one-hot pulse when requester i takes ownership

Behaviour:
- Clocking and reset: one clock, clk_i. Reset srst_i is synchronous and active-high.
- Reset values: state IDLE_S, pending 0, leds_o 0, owner_o 0, busy_o 0, grant_o 0, all counters 0.
- Reset mid-SHOW aborts the show immediately and discards pending requests.
- Request capture:
  - req_i[i]=1 sets pending[i] and stores pattern_i slice i and blink_i[i] into a per-requester register.
  - A repeat request overwrites the stored values (latest wins).
- IDLE_S:
  - If any pending bit is set, pick the lowest set index w and go to SHOW_S.
  - Clear pending[w], owner<=w, grant_o[w] pulses for one clk.
  - Load the hold counter with HOLD_TICKS; clear the blink counter; blink phase = visible.
- SHOW_S:
  - Each sample_tick_i decrements the hold counter.
  - When a tick takes it from 1 to 0, go to IDLE_S. If requests are pending, the next grant follows one clk later.
- Preemption: in SHOW_S, pending[j] with j<owner replaces the owner in the same manner as an IDLE grant (reload, grant pulse). The preempted requester is dropped, not requeued.
- Owner re-request: req_i[owner] during SHOW_S refreshes the stored pattern/blink, reloads the hold counter and does not set pending. It does not pulse grant_o.
- Simultaneous req_i[w] on the grant cycle of w is handled as an owner re-request.
- Blink (owner blink flag=1):
  - The blink counter counts sample ticks modulo BLINK_DIV.
  - On each wrap the phase toggles; the visible phase shows the pattern, the dark phase shows 4'b0000.
  - The first half-period is visible.
- leds_o timing: registered, one clk after the state/phase change. Value is default_leds_i in IDLE_S; otherwise the owner's pattern or 0 per the blink phase.
- Latency: req_i at clk edge t (idle) -> grant_o high in the cycle after edge t+1 -> leds_o updated at edge t+2.
- Show duration: exactly HOLD_TICKS sample ticks counted from the first tick after the grant.
- sample_tick_i and a grant in the same clk: the tick is ignored; the counter is freshly loaded.
- busy_o = (state == SHOW_S). owner_o holds the last owner during SHOW_S and is 0 in IDLE_S.

Decomposition:
- Shared package ind_pkg contains:
  - typedef ind_state_t {IDLE_S, SHOW_S};
  - typedef led_pat_t (logic [3:0]);
  - constant LED_OFF = 4'b0000.
- Sub-module ind_prio_enc: parameterised lowest-set-bit encoder with a valid flag. It is used for both the idle pick and the preemption check (the check compares the winner index against owner).

Test Plan:
- Single request: HOLD_TICKS=4, pattern 4'b1010, no blink, req_i[2] once -> grant_o=4'b0100 two clks later. leds_o=1010 for exactly 4 ticks, then default_leds_i=0011; busy_o falls with the return.
- Simultaneous: req_i=4'b0110 on the same clk -> requester 1 is granted first and shown for 4 ticks. One clk after IDLE_S, requester 2 is granted; leds_o shows pattern 2.
- Preemption: requester 3 showing with 2 ticks left, req_i[0] pattern 1111 -> grant_o=0001 and leds_o=1111 for a full 4 ticks. Requester 3 is never shown again.
- Blink: BLINK_DIV=2, HOLD_TICKS=8, blink=1, pattern 0101 -> leds_o sequence per tick pair 0101, 0000, 0101, 0000, then default.
- Re-request: owner 1 re-requests with pattern 1100 at tick 3 of 4 -> no grant pulse, leds_o=1100, hold lasts 4 further ticks.
- Reset: srst_i mid-SHOW with pending bits set -> next clk leds_o=0, busy_o=0. After release leds_o follows default_leds_i and no grant occurs.

Source files
------------

// File: rtl/led_indicator_arbiter_pkg.sv
// Shared types for the front-panel LED indicator arbiter.
package ind_pkg;

    typedef enum logic {IDLE_S = 1'b0, SHOW_S = 1'b1} ind_state_t;

    typedef logic [3:0] led_pat_t;

    localparam led_pat_t LED_OFF = 4'b0000;

endpackage

// File: rtl/led_indicator_arbiter_prio_enc.sv
// Lowest-set-bit priority encoder; index 0 wins, valid flags a non-empty vector.
module ind_prio_enc #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          valid
);

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_indicator_arbiter.sv
// Fixed-priority arbiter granting the 4 panel LEDs to one-shot requesters
// for a hold window of sample ticks, with optional blinking.
module led_indicator_arbiter
    import ind_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int HOLD_W     = 16,
    parameter int HOLD_TICKS = 24000,
    parameter int BLINK_DIV  = 6000
) (
    input  logic                       clk_i,
    input  logic                       srst_i,
    input  logic                       sample_tick_i,
    input  logic [3:0]                 default_leds_i,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [4*NUM_REQ-1:0]       pattern_i,
    input  logic [NUM_REQ-1:0]         blink_i,
    output logic [3:0]                 leds_o,
    output logic [$clog2(NUM_REQ)-1:0] owner_o,
    output logic                       busy_o,
    output logic [NUM_REQ-1:0]         grant_o
);

    localparam int OW = $clog2(NUM_REQ);

    ind_state_t         state;
    logic [NUM_REQ-1:0] pending;
    led_pat_t           pat_q [NUM_REQ];
    logic [NUM_REQ-1:0] blink_q;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [HOLD_W-1:0]  blink_cnt;
    logic               phase_dark;
    logic [OW-1:0]      owner_q;

    logic [OW-1:0]      win_idx;
    logic               win_vld;
    logic               do_grant;
    logic               reload;
    logic [OW-1:0]      next_owner;
    logic [NUM_REQ-1:0] win_oh;
    logic [NUM_REQ-1:0] owner_oh;

    // One encoder serves both the idle pick and the preemption test.
    ind_prio_enc #(.N(NUM_REQ), .IW(OW)) u_prio_enc (
        .vec   (pending),
        .idx   (win_idx),
        .valid (win_vld)
    );

    always_comb begin
        do_grant   = win_vld && ((state == IDLE_S) || (win_idx < owner_q));
        next_owner = do_grant ? win_idx : owner_q;
        win_oh     = '0;
        owner_oh   = '0;
        if (do_grant) begin
            win_oh[win_idx] = 1'b1;
        end
        // A request from whoever owns the display after this edge is a refresh, not a new claim.
        if (do_grant || (state == SHOW_S)) begin
            owner_oh[next_owner] = 1'b1;
        end
        reload = do_grant || (|(req_i & owner_oh));
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_i[i]) begin
                pat_q[i]   <= pattern_i[4*i +: 4];
                blink_q[i] <= blink_i[i];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state      <= IDLE_S;
            pending    <= '0;
            leds_o     <= LED_OFF;
            owner_q    <= '0;
            grant_o    <= '0;
            hold_cnt   <= '0;
            blink_cnt  <= '0;
            phase_dark <= 1'b0;
        end else begin
            pending <= (pending & ~win_oh) | (req_i & ~owner_oh);
            grant_o <= win_oh;

            if (state == SHOW_S) begin
                leds_o <= (blink_q[owner_q] && phase_dark) ? LED_OFF : pat_q[owner_q];
            end else begin
                leds_o <= default_leds_i;
            end

            if (do_grant) begin
                state      <= SHOW_S;
                owner_q    <= win_idx;
                hold_cnt   <= HOLD_W'(HOLD_TICKS);
                blink_cnt  <= '0;
                phase_dark <= 1'b0;
            end else if (state == SHOW_S) begin
                if (reload) begin
                    hold_cnt <= HOLD_W'(HOLD_TICKS);
                end else if (sample_tick_i) begin
                    hold_cnt <= hold_cnt - HOLD_W'(1);
                    if (hold_cnt == HOLD_W'(1)) begin
                        state   <= IDLE_S;
                        owner_q <= '0;
                    end
                end
                if (sample_tick_i) begin
                    if (blink_cnt == HOLD_W'(BLINK_DIV - 1)) begin
                        blink_cnt  <= '0;
                        phase_dark <= ~phase_dark;
                    end else begin
                        blink_cnt <= blink_cnt + HOLD_W'(1);
                    end
                end
            end
        end
    end

    assign busy_o  = (state == SHOW_S);
    assign owner_o = owner_q;

endmodule

// File: tb/tb_led_indicator_arbiter.sv
// Bench for led_indicator_arbiter: directed scenarios plus random traffic,
// every cycle compared against an abstract show/queue model.
module tb_led_indicator_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int HOLD_W     = 16;
    localparam int HOLD_TICKS = 4;
    localparam int BLINK_DIV  = 2;

    logic        clk = 1'b0;
    logic        srst;
    logic        tick;
    logic [3:0]  dflt;
    logic [3:0]  req;
    logic [15:0] pat;
    logic [3:0]  blk;
    logic [3:0]  leds;
    logic [1:0]  owner;
    logic        busy;
    logic [3:0]  grant;

    int checks = 0;
    int errors = 0;

    led_indicator_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .HOLD_W     (HOLD_W),
        .HOLD_TICKS (HOLD_TICKS),
        .BLINK_DIV  (BLINK_DIV)
    ) dut (
        .clk_i          (clk),
        .srst_i         (srst),
        .sample_tick_i  (tick),
        .default_leds_i (dflt),
        .req_i          (req),
        .pattern_i      (pat),
        .blink_i        (blk),
        .leds_o         (leds),
        .owner_o        (owner),
        .busy_o         (busy),
        .grant_o        (grant)
    );

    always #5 clk = ~clk;

    // Model: who owns the display, how many ticks remain, ticks since the grant.
    int         own = -1;
    int         remaining = 0;
    int         elapsed = 0;
    int         win;
    int         nown;
    bit         reown;
    logic [3:0] pend = '0;
    logic [3:0] spat [NUM_REQ];
    logic [3:0] sblk = '0;
    logic [3:0] m_leds = '0;
    logic [3:0] m_grant = '0;
    logic [3:0] m_owner = '0;
    logic [3:0] m_busy = '0;

    always @(posedge clk) begin
        if (own < 0) m_leds = dflt;
        else if (sblk[own] && (((elapsed / BLINK_DIV) % 2) == 1)) m_leds = 4'b0000;
        else m_leds = spat[own];

        win = -1;
        for (int i = NUM_REQ - 1; i >= 0; i--) if (pend[i]) win = i;
        nown  = (!srst && win >= 0 && (own < 0 || win < own)) ? win : own;
        reown = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i]) begin
                spat[i] = pat[4*i +: 4];
                sblk[i] = blk[i];
                if (i == nown) reown = 1'b1;
                else pend[i] = 1'b1;
            end
        end

        m_grant = '0;
        if (srst) begin
            pend = '0; own = -1; remaining = 0; elapsed = 0; m_leds = 4'b0000;
        end else if (win >= 0 && (own < 0 || win < own)) begin
            pend[win] = 1'b0; own = win; remaining = HOLD_TICKS; elapsed = 0;
            m_grant[win] = 1'b1;
        end else if (own >= 0) begin
            if (tick) elapsed++;
            if (reown) remaining = HOLD_TICKS;
            else if (tick) begin
                remaining--;
                if (remaining == 0) own = -1;
            end
        end
        m_busy  = (own >= 0) ? 4'd1 : 4'd0;
        m_owner = (own >= 0) ? 4'(own) : 4'd0;
    end

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("model_leds", leds, m_leds);
        chk("model_grant", grant, m_grant);
        chk("model_owner", 4'(owner), m_owner);
        chk("model_busy", 4'(busy), m_busy);
    endtask

    task automatic step(input logic [3:0] r, input bit t);
        req  = r;
        tick = t;
        @(negedge clk);
        check_all();
        req  = '0;
        tick = 1'b0;
    endtask

    task automatic setp(input int i, input logic [3:0] p, input bit b);
        pat[4*i +: 4] = p;
        blk[i]        = b;
    endtask

    initial begin
        srst = 1'b1; tick = 1'b0; dflt = 4'b0011; req = '0; pat = '0; blk = '0;
        step(4'h0, 0);
        step(4'h0, 0);
        chk("reset_leds", leds, 4'h0);
        chk("reset_grant", grant, 4'h0);
        chk("reset_busy", 4'(busy), 4'h0);
        chk("reset_owner", 4'(owner), 4'h0);
        srst = 1'b0;
        step(4'h0, 0);
        chk("idle_default", leds, 4'b0011);

        // Single request from requester 2
        setp(2, 4'b1010, 1'b0);
        step(4'b0100, 0);
        chk("single_no_early_grant", grant, 4'h0);
        step(4'h0, 0);
        chk("single_grant", grant, 4'b0100);
        step(4'h0, 0);
        chk("single_leds", leds, 4'b1010);
        for (int k = 0; k < 4; k++) begin
            step(4'h0, 1);
            if (k < 3) chk("single_hold", leds, 4'b1010);
        end
        chk("single_busy_fall", 4'(busy), 4'h0);
        step(4'h0, 0);
        chk("single_return", leds, 4'b0011);

        // Simultaneous requests 1 and 2
        setp(1, 4'b1001, 1'b0);
        setp(2, 4'b0110, 1'b0);
        step(4'b0110, 0);
        step(4'h0, 0);
        chk("simul_first", grant, 4'b0010);
        for (int k = 0; k < 4; k++) step(4'h0, 1);
        step(4'h0, 0);
        chk("simul_second", grant, 4'b0100);
        step(4'h0, 0);
        chk("simul_pat2", leds, 4'b0110);
        for (int k = 0; k < 4; k++) step(4'h0, 1);
        step(4'h0, 0);

        // Preemption of requester 3 by requester 0
        setp(3, 4'b0111, 1'b0);
        step(4'b1000, 0);
        step(4'h0, 0);
        chk("preempt_owner3", grant, 4'b1000);
        step(4'h0, 1);
        step(4'h0, 1);
        setp(0, 4'b1111, 1'b0);
        step(4'b0001, 0);
        step(4'h0, 0);
        chk("preempt_grant", grant, 4'b0001);
        step(4'h0, 0);
        chk("preempt_leds", leds, 4'b1111);
        for (int k = 0; k < 4; k++) begin
            step(4'h0, 1);
            if (k < 3) chk("preempt_hold", leds, 4'b1111);
        end
        for (int k = 0; k < 3; k++) step(4'h0, 0);
        chk("preempt_no_requeue", 4'(busy), 4'h0);
        chk("preempt_default", leds, 4'b0011);

        // Blinking pattern
        setp(0, 4'b0101, 1'b1);
        step(4'b0001, 0);
        step(4'h0, 0);
        step(4'h0, 0);
        chk("blink_visible", leds, 4'b0101);
        step(4'h0, 1);
        step(4'h0, 1);
        step(4'h0, 0);
        chk("blink_dark", leds, 4'b0000);
        step(4'h0, 1);
        step(4'h0, 1);
        step(4'h0, 0);
        chk("blink_end", leds, 4'b0011);

        // Owner re-request extends the window
        setp(1, 4'b0011, 1'b0);
        step(4'b0010, 0);
        step(4'h0, 0);
        for (int k = 0; k < 3; k++) step(4'h0, 1);
        setp(1, 4'b1100, 1'b0);
        step(4'b0010, 0);
        chk("rereq_no_grant", grant, 4'h0);
        step(4'h0, 0);
        chk("rereq_leds", leds, 4'b1100);
        for (int k = 0; k < 3; k++) step(4'h0, 1);
        chk("rereq_still_busy", 4'(busy), 4'h1);
        step(4'h0, 1);
        chk("rereq_done", 4'(busy), 4'h0);

        // Reset in the middle of a show with a pending request
        setp(2, 4'b1010, 1'b0);
        step(4'b0100, 0);
        step(4'h0, 0);
        step(4'h0, 0);
        setp(3, 4'b0111, 1'b0);
        step(4'b1000, 0);
        srst = 1'b1;
        step(4'h0, 0);
        chk("midreset_leds", leds, 4'h0);
        chk("midreset_busy", 4'(busy), 4'h0);
        srst = 1'b0;
        dflt = 4'b0101;
        for (int k = 0; k < 6; k++) begin
            step(4'h0, k[0]);
            chk("midreset_no_grant", grant, 4'h0);
        end
        chk("midreset_default", leds, 4'b0101);

        // Random traffic against the model
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 19) == 0) dflt = 4'($urandom);
            for (int i = 0; i < NUM_REQ; i++) setp(i, 4'($urandom), 1'($urandom));
            srst = ($urandom_range(0, 249) == 0);
            step(($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0, ($urandom_range(0, 2) == 0));
            srst = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
